// File: rtl/op_dispatch_mdr.sv
// op_dispatch_mdr
//   Sequential dispatcher for the MDR datapath. It accepts one op request at a
//   time over a valid/ready handshake and pulses a one-hot start to the chosen
//   unit. It holds the one-hot select until that unit reports done, then emits
//   one done pulse. Invalid op codes, unit timeouts and enable-drop aborts each
//   produce a 1-cycle error pulse with a code.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | ready for a request when enabled
//   START | 1-cycle start pulse to the selected unit, timer cleared
//   WAIT  | select held, waiting for the unit's done or a timeout
//   DONE  | 1-cycle completion pulse
//   ERR   | 1-cycle error pulse with code (01 bad op, 10 timeout, 11 abort)
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_enable            block enable; low blocks acceptance and aborts ops
//   i_valid, i_op       request handshake and op code
//   o_ready             request accepted when high together with i_valid
//   o_start, o_sel      one-hot start pulse / held select to the units
//   i_done              per-unit done (level or pulse)
//   o_done, o_busy      completion pulse / op in flight
//   o_err, o_err_code   error pulse and its code
module op_dispatch_mdr #(
    parameter int N_OPS   = 4,
    parameter int OP_W    = 2,
    parameter int TIMEOUT = 200,
    parameter int TMR_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [OP_W-1:0]  i_op,
    output logic             o_ready,
    output logic [N_OPS-1:0] o_start,
    output logic [N_OPS-1:0] o_sel,
    input  logic [N_OPS-1:0] i_done,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_err_code
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0]      ERR_BAD_OP  = 2'b01;
    localparam logic [1:0]      ERR_TIMEOUT = 2'b10;
    localparam logic [1:0]      ERR_ABORT   = 2'b11;
    localparam logic [OP_W:0]   OP_LIMIT    = (OP_W+1)'(N_OPS);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        code_q, code_d;
    logic [N_OPS-1:0]  op_onehot;
    logic              ready;
    logic              done_hit;

    always_comb begin
        for (int i = 0; i < N_OPS; i++) begin
            op_onehot[i] = (op_q == OP_W'(i));
        end
    end

    // Only the selected unit's done bit can complete the op.
    assign done_hit = |(i_done & op_onehot);
    assign ready    = (state_q == IDLE) && i_enable;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        timer_d = timer_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (i_valid && ready) begin
                    if ({1'b0, i_op} < OP_LIMIT) begin
                        op_d    = i_op;
                        state_d = START;
                    end else begin
                        code_d  = ERR_BAD_OP;
                        state_d = ERR;
                    end
                end
            end
            START: begin
                timer_d = '0;
                if (!i_enable) begin
                    code_d  = ERR_ABORT;
                    state_d = ERR;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (!i_enable) begin
                    code_d  = ERR_ABORT;
                    state_d = ERR;
                end else if (done_hit) begin
                    state_d = DONE;
                end else if (timer_q == TMR_LAST) begin
                    code_d  = ERR_TIMEOUT;
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            timer_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            timer_q <= timer_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        o_ready    = ready;
        o_start    = '0;
        o_sel      = '0;
        o_done     = 1'b0;
        o_busy     = 1'b0;
        o_err      = 1'b0;
        o_err_code = 2'b00;
        case (state_q)
            START: begin
                o_start = op_onehot;
                o_sel   = op_onehot;
                o_busy  = 1'b1;
            end
            WAIT: begin
                o_sel  = op_onehot;
                o_busy = 1'b1;
            end
            DONE: o_done = 1'b1;
            ERR: begin
                o_err      = 1'b1;
                o_err_code = code_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_op_dispatch_mdr.sv
module tb_op_dispatch_mdr;

    logic       clk = 1'b0;
    logic       rst, en, valid;
    logic [1:0] op;
    logic [3:0] done_in;
    logic       ready;
    logic [3:0] start, sel;
    logic       done_out, busy, err;
    logic [1:0] code;

    // second instance with only three units, so op code 3 is invalid
    logic       valid3;
    logic [1:0] op3;
    logic [2:0] done3_in;
    logic       ready3, done3_out, busy3, err3;
    logic [2:0] start3, sel3;
    logic [1:0] code3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    op_dispatch_mdr #(.N_OPS(4), .OP_W(2), .TIMEOUT(200), .TMR_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid), .i_op(op),
        .o_ready(ready), .o_start(start), .o_sel(sel), .i_done(done_in),
        .o_done(done_out), .o_busy(busy), .o_err(err), .o_err_code(code)
    );

    op_dispatch_mdr #(.N_OPS(3), .OP_W(2), .TIMEOUT(200), .TMR_W(8)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid3), .i_op(op3),
        .o_ready(ready3), .o_start(start3), .o_sel(sel3), .i_done(done3_in),
        .o_done(done3_out), .o_busy(busy3), .o_err(err3), .o_err_code(code3)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        valid;
        logic [1:0]  op;
        logic [3:0]  done;
        logic [13:0] exp;   // {ready, start, sel, done, busy, err, code}
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic r, logic e, logic v, logic [1:0] o, logic [3:0] d,
                                logic x_rdy, logic [3:0] x_st, logic [3:0] x_sel,
                                logic x_dn, logic x_bsy, logic x_err, logic [1:0] x_code);
        vec_t t;
        t.rst   = r;
        t.en    = e;
        t.valid = v;
        t.op    = o;
        t.done  = d;
        t.exp   = {x_rdy, x_st, x_sel, x_dn, x_bsy, x_err, x_code};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {ready, start, sel, done_out, busy, err, code};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // basic op 1 with done ignored in START, done 3 cycles later
        vecs[0]  = mk(1,0,0,0,4'b0000, 0,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[1]  = mk(1,1,0,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[2]  = mk(0,1,1,1,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[3]  = mk(0,1,0,0,4'b0010, 0,4'b0010,4'b0010,0,1,0,2'b00);
        vecs[4]  = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b0010,0,1,0,2'b00);
        vecs[5]  = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b0010,0,1,0,2'b00);
        vecs[6]  = mk(0,1,0,0,4'b0010, 0,4'b0000,4'b0010,0,1,0,2'b00);
        vecs[7]  = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b0000,1,0,0,2'b00);
        vecs[8]  = mk(0,1,0,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        // enable drop in WAIT (beats done), then idle with enable low
        vecs[9]  = mk(0,1,1,3,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[10] = mk(0,1,0,0,4'b0000, 0,4'b1000,4'b1000,0,1,0,2'b00);
        vecs[11] = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b1000,0,1,0,2'b00);
        vecs[12] = mk(0,0,0,0,4'b1000, 0,4'b0000,4'b1000,0,1,0,2'b00);
        vecs[13] = mk(0,0,0,0,4'b0000, 0,4'b0000,4'b0000,0,0,1,2'b11);
        vecs[14] = mk(0,0,1,2,4'b0000, 0,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[15] = mk(0,0,1,2,4'b0000, 0,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[16] = mk(0,1,0,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        // enable drop in START
        vecs[17] = mk(0,1,1,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[18] = mk(0,0,0,0,4'b0000, 0,4'b0001,4'b0001,0,1,0,2'b00);
        vecs[19] = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b0000,0,0,1,2'b11);
        vecs[20] = mk(0,1,0,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        // reset in WAIT (beats done), then a new op runs normally
        vecs[21] = mk(0,1,1,2,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[22] = mk(0,1,0,0,4'b0000, 0,4'b0100,4'b0100,0,1,0,2'b00);
        vecs[23] = mk(1,1,0,0,4'b0100, 0,4'b0000,4'b0100,0,1,0,2'b00);
        vecs[24] = mk(0,1,1,1,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);
        vecs[25] = mk(0,1,0,0,4'b0000, 0,4'b0010,4'b0010,0,1,0,2'b00);
        vecs[26] = mk(0,1,0,0,4'b0010, 0,4'b0000,4'b0010,0,1,0,2'b00);
        vecs[27] = mk(0,1,0,0,4'b0000, 0,4'b0000,4'b0000,1,0,0,2'b00);
        vecs[28] = mk(0,1,0,0,4'b0000, 1,4'b0000,4'b0000,0,0,0,2'b00);

        rst = 1'b1; en = 1'b1; valid = 1'b0; op = 2'd0; done_in = 4'b0;
        valid3 = 1'b0; op3 = 2'd0; done3_in = 3'b0;
        step();
        step();

        for (int i = 0; i < 29; i++) begin
            rst     = vecs[i].rst;
            en      = vecs[i].en;
            valid   = vecs[i].valid;
            op      = vecs[i].op;
            done_in = vecs[i].done;
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            step();
        end

        // timeout: op 0, done never arrives
        rst = 1'b0; en = 1'b1; done_in = 4'b0;
        valid = 1'b1; op = 2'd0;
        step();
        valid = 1'b0;
        #1;
        check("to_start", 32'(start), 32'h1);
        step();
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        check("to_wait_cycles", 32'(n), 32'd200);
        check("to_err", 32'({err, code, sel, done_out}), 32'({1'b1, 2'b10, 4'b0000, 1'b0}));
        step();
        check("to_idle", 32'({ready, err, busy}), 32'({1'b1, 1'b0, 1'b0}));

        // wrong-unit done ignored; right done on the last timer cycle wins
        valid = 1'b1; op = 2'd2;
        step();
        valid = 1'b0;
        step();
        for (int k = 1; k <= 200; k++) begin
            done_in = (k == 200) ? 4'b0101 : 4'b0001;
            step();
        end
        done_in = 4'b0;
        #1;
        check("late_done", 32'({done_out, err, code, sel}), 32'({1'b1, 1'b0, 2'b00, 4'b0000}));
        step();
        check("late_idle", 32'({ready, done_out, err}), 32'({1'b1, 1'b0, 1'b0}));

        // invalid op on the three-unit instance
        valid3 = 1'b1; op3 = 2'd3;
        #1;
        check("bad_ready", 32'(ready3), 32'h1);
        step();
        valid3 = 1'b0;
        #1;
        check("bad_err", 32'({start3, busy3, err3, code3, done3_out}),
              32'({3'b000, 1'b0, 1'b1, 2'b01, 1'b0}));
        step();
        check("bad_idle", 32'({ready3, err3, code3}), 32'({1'b1, 1'b0, 2'b00}));
        valid3 = 1'b1; op3 = 2'd2;
        step();
        valid3 = 1'b0;
        #1;
        check("n3_start", 32'({start3, sel3, busy3}), 32'({3'b100, 3'b100, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
